// File: rtl/fsk_demod.sv
// 2-FSK bit-window demodulator: counts line edges per window, decodes 16-bit frames.
// Optional ambiguous-window flag enabled with `define FSK_DEMOD_ERR_EN.
module fsk_demod #(
  parameter int unsigned SAMPLES_PER_BIT = 128,
  parameter int unsigned EDGE_THRESH     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fsk_in,
  input  logic        start,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        err
);

  localparam int unsigned WIN_W   = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync2_d;
  logic [WIN_W-1:0]     r_win_cnt;
  logic [CNT_W-1:0]     r_edge_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [FRAME_W-1:0]   r_shift;
  logic [FRAME_W-1:0]   r_data_out;
  logic                 r_data_valid;

  logic                 w_edge;
  logic [CNT_W-1:0]     w_edge_sum;
  logic                 w_bit;
  logic                 w_win_end;
  logic                 w_frame_done;
  logic [FRAME_W-1:0]   w_shift_nxt;

  assign w_edge       = r_sync2 ^ r_sync2_d;
  // Edge count including this cycle's edge, saturating at the counter ceiling
  assign w_edge_sum   = (r_edge_cnt == {CNT_W{1'b1}}) ? r_edge_cnt
                                                       : r_edge_cnt + CNT_W'(w_edge);
  assign w_bit        = (w_edge_sum >= CNT_W'(EDGE_THRESH));
  assign w_win_end    = (r_state == RECV) && !start &&
                        (r_win_cnt == WIN_W'(SAMPLES_PER_BIT - 1));
  assign w_frame_done = w_win_end && (r_bit_idx == '0);
  assign w_shift_nxt  = {r_shift[FRAME_W-2:0], w_bit};

  // Next-state logic; start from either state (re)arms reception
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RECV;
      RECV:    w_state_nxt = RECV;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync2_d    <= 1'b0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync1      <= fsk_in;
      r_sync2      <= r_sync1;
      r_sync2_d    <= r_sync2;
      r_data_valid <= 1'b0;
      if (start) begin
        r_win_cnt  <= '0;
        r_edge_cnt <= '0;
        r_bit_idx  <= IDX_W'(FRAME_W - 1);
        r_shift    <= '0;
      end else if (r_state == RECV) begin
        if (w_win_end) begin
          r_win_cnt  <= '0;
          r_edge_cnt <= '0;
          r_shift    <= w_shift_nxt;
          // Index wraps 0 -> 15 so the next frame follows with no gap
          r_bit_idx  <= r_bit_idx - IDX_W'(1);
          if (w_frame_done) begin
            r_data_out   <= w_shift_nxt;
            r_data_valid <= 1'b1;
          end
        end else begin
          r_win_cnt  <= r_win_cnt + WIN_W'(1);
          r_edge_cnt <= w_edge_sum;
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

`ifdef FSK_DEMOD_ERR_EN
  logic r_err;

  // Flag windows whose edge count sits between the nominal space and mark tones
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_win_end && (w_edge_sum >= CNT_W'(12)) && (w_edge_sum <= CNT_W'(27));
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fsk_demod.sv
// Directed bench for fsk_demod: modulated frames, back-to-back frames, reset and restart.
module tb_fsk_demod;

  localparam int SPB = 128;

  logic        clk;
  logic        rst;
  logic        fsk_in;
  logic        start;
  logic [15:0] data_out;
  logic        data_valid;
  logic        err;

  fsk_demod #(.SAMPLES_PER_BIT(SPB), .EDGE_THRESH(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .fsk_in    (fsk_in),
    .start     (start),
    .data_out  (data_out),
    .data_valid(data_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          line_j;
  bit          line_on;
  bit          alt8;
  logic [31:0] frame_bits;
  int          nbits;
  int          n_dv;
  int          n_err;
  int          dv1_cyc;
  int          dv2_cyc;
  logic [15:0] dv1_data;
  logic [15:0] dv2_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then drive the next line sample.
  // A pulse registered at edge cyc is the value seen at edge cyc+1.
  task automatic tick();
    int k;
    int per;
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid === 1'b1) begin
      n_dv++;
      if (n_dv == 1) begin dv1_cyc = cyc + 1; dv1_data = data_out; end
      if (n_dv == 2) begin dv2_cyc = cyc + 1; dv2_data = data_out; end
    end
    if (err === 1'b1) n_err++;
    if (line_on) begin
      k = line_j / SPB;
      if (k < nbits) begin
        per = alt8 ? 8 : (frame_bits[31-k] ? 4 : 16);
        if (line_j % per == 0) fsk_in = ~fsk_in;
      end
      line_j++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clr_stats();
    n_dv = 0; n_err = 0; dv1_cyc = -1; dv2_cyc = -1; dv1_data = 'x; dv2_data = 'x;
  endtask

  task automatic do_reset(input bit start_in_reset);
    rst = 1'b0; start = start_in_reset; line_on = 1'b0; fsk_in = 1'b0; alt8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1; start = 1'b0;
    clr_stats();
  endtask

  // Arm a line starting right after the start edge, which becomes cycle 0
  task automatic start_frame(input logic [31:0] bits, input int nb, input bit a8);
    frame_bits = bits; nbits = nb; alt8 = a8;
    line_j = 0; line_on = 1'b1;
    start = 1'b1; cyc = -1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; fsk_in = 1'b0; cyc = 0; line_j = 0; line_on = 1'b0;
    alt8 = 1'b0; frame_bits = '0; nbits = 0;
    clr_stats();

    // Reset state; start held during reset must not arm the receiver
    do_reset(1'b1);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    cyc = 0; run_to(2200);
    chk("idle_no_valid", 32'(n_dv), 32'd0);

    // Single frame A5C3
    start_frame({16'hA5C3, 16'h0000}, 16, 1'b0);
    run_to(2060);
    chk("a5c3_valid_count", 32'(n_dv), 32'd1);
    chk("a5c3_valid_cycle", 32'(dv1_cyc), 32'd2049);
    chk("a5c3_data", 32'(dv1_data), 32'hA5C3);
    chk("a5c3_err_count", 32'(n_err), 32'd0);
    chk("a5c3_hold", 32'(data_out), 32'hA5C3);

    // Back-to-back FFFF then 0000 with one start
    do_reset(1'b0);
    chk("rst2_data_out", 32'(data_out), 32'h0);
    start_frame(32'hFFFF_0000, 32, 1'b0);
    run_to(4100);
    chk("b2b_valid_count", 32'(n_dv), 32'd2);
    chk("b2b_cycle1", 32'(dv1_cyc), 32'd2049);
    chk("b2b_data1", 32'(dv1_data), 32'hFFFF);
    chk("b2b_cycle2", 32'(dv2_cyc), 32'd4097);
    chk("b2b_data2", 32'(dv2_data), 32'h0000);

    // Reset at T+1000 mid-frame after a nonzero frame was latched
    do_reset(1'b0);
    start_frame({16'h5A5A, 16'h0000}, 16, 1'b0);
    run_to(2060);
    chk("pre_midrst_data", 32'(data_out), 32'h5A5A);
    start_frame({16'hA5C3, 16'h0000}, 16, 1'b0);
    clr_stats();
    run_to(999);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_data_out", 32'(data_out), 32'h0);
    run_to(3000);
    chk("midrst_no_valid", 32'(n_dv), 32'd0);
    chk("midrst_data_hold0", 32'(data_out), 32'h0);

    // Restart at T+700 discards the partial frame
    do_reset(1'b0);
    start_frame({16'hFFFF, 16'h0000}, 16, 1'b0);
    run_to(699);
    start_frame({16'hA5C3, 16'h0000}, 16, 1'b0);
    run_to(2060);
    chk("restart_valid_count", 32'(n_dv), 32'd1);
    chk("restart_valid_cycle", 32'(dv1_cyc), 32'd2049);
    chk("restart_data", 32'(dv1_data), 32'hA5C3);

    // Ambiguous line: 16 edges per window decodes 0
    do_reset(1'b0);
    start_frame(32'hFFFF_0000, 16, 1'b1);
    run_to(2060);
    chk("amb_valid_count", 32'(n_dv), 32'd1);
    chk("amb_data", 32'(dv1_data), 32'h0000);
`ifdef FSK_DEMOD_ERR_EN
    chk("amb_err_count", 32'(n_err), 32'd16);
`else
    chk("amb_err_count", 32'(n_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
